// File: rtl/clause_bound_accumulator_pkg.sv
// Shared constants and state encoding for the clause bound accumulator.
// Bounds are signed; MIN/MAX here are for the default bound width.
package clause_bound_accumulator_pkg;

    localparam int BIT_WIDTH_OF_INTEGER_VARIABLE = 16;
    localparam int DEFAULT_NUMBER_OF_CLAUSES     = 4;

    typedef enum logic [1:0] {
        STATE_IDLE    = 2'd0,
        STATE_COLLECT = 2'd1,
        STATE_DONE    = 2'd2
    } state_t;

    localparam logic signed [BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] SIGNED_MIN =
        {1'b1, {(BIT_WIDTH_OF_INTEGER_VARIABLE-1){1'b0}}};
    localparam logic signed [BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] SIGNED_MAX =
        {1'b0, {(BIT_WIDTH_OF_INTEGER_VARIABLE-1){1'b1}}};

endpackage

// File: rtl/clause_bound_accumulator_bound_update.sv
// Combinational intersection of one reduced clause (+/-)y <= b into [lower, upper].
// A lower candidate is -b, saturated so that negating the most negative value yields MAX.
module bound_update
    import clause_bound_accumulator_pkg::*;
#(
    parameter int BIT_WIDTH = BIT_WIDTH_OF_INTEGER_VARIABLE
) (
    input  logic signed [BIT_WIDTH-1:0] lower,
    input  logic signed [BIT_WIDTH-1:0] upper,
    input  logic signed [BIT_WIDTH-1:0] bias,
    input  logic                        sign,
    input  logic                        active,
    output logic signed [BIT_WIDTH-1:0] next_lower,
    output logic signed [BIT_WIDTH-1:0] next_upper
);

    localparam logic signed [BIT_WIDTH-1:0] MIN_VALUE = {1'b1, {(BIT_WIDTH-1){1'b0}}};
    localparam logic signed [BIT_WIDTH-1:0] MAX_VALUE = {1'b0, {(BIT_WIDTH-1){1'b1}}};

    logic signed [BIT_WIDTH-1:0] lower_candidate;

    always_comb begin
        lower_candidate = (bias == MIN_VALUE) ? MAX_VALUE : -bias;
        next_lower      = lower;
        next_upper      = upper;
        if (active) begin
            if (sign) begin
                if (bias < upper) begin
                    next_upper = bias;
                end
            end else begin
                if (lower_candidate > lower) begin
                    next_lower = lower_candidate;
                end
            end
        end
    end

endmodule

// File: rtl/clause_bound_accumulator.sv
// Intersects a stream of reduced single-variable clauses into one interval
// [lower, upper] and reports, once per collection, whether it is non-empty.
module clause_bound_accumulator
    import clause_bound_accumulator_pkg::*;
#(
    parameter int BIT_WIDTH         = BIT_WIDTH_OF_INTEGER_VARIABLE,
    parameter int NUMBER_OF_CLAUSES = DEFAULT_NUMBER_OF_CLAUSES,
    parameter int COUNT_WIDTH       = $clog2(NUMBER_OF_CLAUSES + 1)
) (
    input  logic                        in_clk,
    input  logic                        in_reset,
    input  logic                        in_start,
    input  logic                        in_valid,
    input  logic signed [BIT_WIDTH-1:0] in_bias,
    input  logic                        in_sign,
    input  logic                        in_active,
    output logic                        out_ready,
    output logic                        out_busy,
    output logic signed [BIT_WIDTH-1:0] out_lower_bound,
    output logic signed [BIT_WIDTH-1:0] out_upper_bound,
    output logic                        out_feasible,
    output logic                        out_done
);

    // state   | meaning
    // IDLE    | holding last result, waiting for in_start
    // COLLECT | accepting clauses, bounds show running intersection
    // DONE    | result valid for one cycle; in_start restarts directly

    localparam logic signed [BIT_WIDTH-1:0] MIN_VALUE = {1'b1, {(BIT_WIDTH-1){1'b0}}};
    localparam logic signed [BIT_WIDTH-1:0] MAX_VALUE = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic [COUNT_WIDTH-1:0]      LAST_INDEX = COUNT_WIDTH'(NUMBER_OF_CLAUSES - 1);

    state_t                      state;
    logic [COUNT_WIDTH-1:0]      count;
    logic signed [BIT_WIDTH-1:0] lower_bound;
    logic signed [BIT_WIDTH-1:0] upper_bound;
    logic                        feasible;
    logic                        done;
    logic signed [BIT_WIDTH-1:0] next_lower;
    logic signed [BIT_WIDTH-1:0] next_upper;

    bound_update #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_bound_update (
        .lower      (lower_bound),
        .upper      (upper_bound),
        .bias       (in_bias),
        .sign       (in_sign),
        .active     (in_active),
        .next_lower (next_lower),
        .next_upper (next_upper)
    );

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state       <= STATE_IDLE;
            count       <= '0;
            lower_bound <= '0;
            upper_bound <= '0;
            feasible    <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                STATE_IDLE: begin
                    if (in_start) begin
                        state       <= STATE_COLLECT;
                        count       <= '0;
                        lower_bound <= MIN_VALUE;
                        upper_bound <= MAX_VALUE;
                    end
                end
                STATE_COLLECT: begin
                    if (in_valid) begin
                        count       <= count + 1'b1;
                        lower_bound <= next_lower;
                        upper_bound <= next_upper;
                        if (count == LAST_INDEX) begin
                            state    <= STATE_DONE;
                            feasible <= (next_lower <= next_upper);
                            done     <= 1'b1;
                        end
                    end
                end
                STATE_DONE: begin
                    if (in_start) begin
                        state       <= STATE_COLLECT;
                        count       <= '0;
                        lower_bound <= MIN_VALUE;
                        upper_bound <= MAX_VALUE;
                    end else begin
                        state <= STATE_IDLE;
                    end
                end
                default: begin
                    state <= STATE_IDLE;
                end
            endcase
        end
    end

    // state is a flop, so these decodes are glitch-free
    assign out_ready       = (state == STATE_COLLECT);
    assign out_busy        = (state == STATE_COLLECT);
    assign out_lower_bound = lower_bound;
    assign out_upper_bound = upper_bound;
    assign out_feasible    = feasible;
    assign out_done        = done;

endmodule

// File: tb/tb_clause_bound_accumulator.sv
// Directed and randomized bench for clause_bound_accumulator (16-bit, 3 clauses)
// against an integer-arithmetic interval model.
module tb_clause_bound_accumulator;

    typedef int arr3_t[3];

    logic               in_clk = 1'b0;
    logic               in_reset = 1'b1;
    logic               in_start = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] in_bias = '0;
    logic               in_sign = 1'b0;
    logic               in_active = 1'b0;
    logic               out_ready;
    logic               out_busy;
    logic signed [15:0] out_lower_bound;
    logic signed [15:0] out_upper_bound;
    logic               out_feasible;
    logic               out_done;

    int errors = 0;
    int checks = 0;
    bit prev_feasible = 1'b0;

    clause_bound_accumulator #(
        .BIT_WIDTH         (16),
        .NUMBER_OF_CLAUSES (3)
    ) dut (
        .in_clk          (in_clk),
        .in_reset        (in_reset),
        .in_start        (in_start),
        .in_valid        (in_valid),
        .in_bias         (in_bias),
        .in_sign         (in_sign),
        .in_active       (in_active),
        .out_ready       (out_ready),
        .out_busy        (out_busy),
        .out_lower_bound (out_lower_bound),
        .out_upper_bound (out_upper_bound),
        .out_feasible    (out_feasible),
        .out_done        (out_done)
    );

    always #5 in_clk = ~in_clk;

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Interval after the first n clauses, using plain integer arithmetic.
    function automatic void model(input arr3_t b, input arr3_t s, input arr3_t a, input int n,
                                  output int lo, output int hi);
        int c;
        lo = -32768;
        hi = 32767;
        for (int i = 0; i < n; i++) begin
            if (a[i] != 0) begin
                if (s[i] != 0) begin
                    if (b[i] < hi) hi = b[i];
                end else begin
                    c = -b[i];
                    if (c > 32767) c = 32767;
                    if (c > lo) lo = c;
                end
            end
        end
    endfunction

    task automatic run_collection(input arr3_t b, input arr3_t s, input arr3_t a, input int gap,
                                  input bit already_started, input bit valid_with_start,
                                  input bit start_in_gaps, input bit hold_start);
        int lo, hi;
        bit exp_feas;
        if (!already_started) begin
            in_start = 1'b1;
            if (valid_with_start) begin
                in_valid  = 1'b1;
                in_bias   = -16'sd100;
                in_sign   = 1'b1;
                in_active = 1'b1;
            end
            step();
            in_start = 1'b0;
            in_valid = 1'b0;
        end
        check("busy_after_start", 32'(out_busy), 1);
        check("ready_after_start", 32'(out_ready), 1);
        check("lower_init", 32'(out_lower_bound), -32768);
        check("upper_init", 32'(out_upper_bound), 32767);
        check("done_after_start", 32'(out_done), 0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                for (int g = 0; g < gap; g++) begin
                    in_start = start_in_gaps;
                    in_valid = 1'b0;
                    in_bias  = 16'($urandom_range(0, 65535));
                    step();
                    in_start = 1'b0;
                    check("done_in_gap", 32'(out_done), 0);
                    check("busy_in_gap", 32'(out_busy), 1);
                end
            end
            in_valid  = 1'b1;
            in_bias   = 16'(b[k]);
            in_sign   = (s[k] != 0);
            in_active = (a[k] != 0);
            step();
            in_valid = 1'b0;
            model(b, s, a, k + 1, lo, hi);
            check("lower_running", 32'(out_lower_bound), lo);
            check("upper_running", 32'(out_upper_bound), hi);
            if (k < 2) begin
                check("done_early", 32'(out_done), 0);
                check("feasible_held", 32'(out_feasible), 32'(prev_feasible));
            end
        end
        exp_feas = (lo <= hi);
        check("done_pulse", 32'(out_done), 1);
        check("busy_in_done", 32'(out_busy), 0);
        check("feasible", 32'(out_feasible), 32'(exp_feas));
        prev_feasible = exp_feas;
        in_start = hold_start;
        step();
        in_start = 1'b0;
        check("done_one_cycle", 32'(out_done), 0);
        check("busy_after_done", 32'(out_busy), 32'(hold_start));
        if (!hold_start) begin
            check("lower_hold", 32'(out_lower_bound), lo);
            check("upper_hold", 32'(out_upper_bound), hi);
        end
    endtask

    function automatic int rand_bias();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return -32768;
        if (r == 1) return 32767;
        if (r < 5) return int'($urandom_range(0, 40)) - 20;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    initial begin
        arr3_t b, s, a;

        in_reset = 1'b1;
        step();
        step();
        in_reset = 1'b0;
        check("reset_lower", 32'(out_lower_bound), 0);
        check("reset_upper", 32'(out_upper_bound), 0);
        check("reset_feasible", 32'(out_feasible), 0);
        check("reset_done", 32'(out_done), 0);
        check("reset_ready", 32'(out_ready), 0);
        check("reset_busy", 32'(out_busy), 0);

        // clauses offered in IDLE must be ignored
        in_valid = 1'b1; in_bias = 16'sd5; in_sign = 1'b1; in_active = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        check("idle_valid_upper", 32'(out_upper_bound), 0);
        check("idle_valid_busy", 32'(out_busy), 0);

        b = '{10, 3, 7}; s = '{1, 0, 1}; a = '{1, 1, 1};
        run_collection(b, s, a, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        b = '{2, -5, 0}; s = '{1, 0, 1}; a = '{1, 1, 0};
        run_collection(b, s, a, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        b = '{100, -7, 3}; s = '{1, 0, 1}; a = '{0, 0, 0};
        run_collection(b, s, a, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        b = '{-32768, 9, -9}; s = '{0, 1, 0}; a = '{1, 0, 0};
        run_collection(b, s, a, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // gaps of 2 with in_start asserted during COLLECT, then stray valids in IDLE
        b = '{10, 3, 7}; s = '{1, 0, 1}; a = '{1, 1, 1};
        run_collection(b, s, a, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b1; in_bias = -16'sd1; in_sign = 1'b1; in_active = 1'b1;
        step();
        in_valid = 1'b0;
        check("idle_valid_done", 32'(out_done), 0);

        // reset in mid-collection discards partial state
        in_start = 1'b1;
        step();
        in_start = 1'b0;
        in_valid = 1'b1; in_bias = 16'sd4; in_sign = 1'b1; in_active = 1'b1;
        step();
        in_bias = 16'sd2; in_sign = 1'b0;
        step();
        in_valid = 1'b0;
        in_reset = 1'b1;
        step();
        in_reset = 1'b0;
        prev_feasible = 1'b0;
        check("midreset_lower", 32'(out_lower_bound), 0);
        check("midreset_upper", 32'(out_upper_bound), 0);
        check("midreset_feasible", 32'(out_feasible), 0);
        check("midreset_busy", 32'(out_busy), 0);
        check("midreset_done", 32'(out_done), 0);

        // fresh run ending with in_start held in DONE -> immediate restart
        b = '{-1, 20, 30}; s = '{0, 1, 0}; a = '{1, 1, 1};
        run_collection(b, s, a, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        b = '{50, -50, 40}; s = '{1, 0, 1}; a = '{1, 1, 1};
        run_collection(b, s, a, 1, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 3; i++) begin
                b[i] = rand_bias();
                s[i] = int'($urandom_range(0, 1));
                a[i] = ($urandom_range(0, 3) != 0) ? 1 : 0;
            end
            run_collection(b, s, a, int'($urandom_range(0, 2)), 1'b0, 1'b0,
                           ($urandom_range(0, 1) != 0), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
